cv32e40p_obi_instr_responder: RTL
=================================

# cv32e40p_obi_instr_responder

Responder (memory side) of the OBI instruction-fetch interface driven by the IF stage's prefetch buffer. Accepts fetch requests, returns instruction words from an internal word-addressed array, and flags out-of-range accesses with a bus error. It serves as the instruction memory model for core-level benches and small integrations. A backdoor load port preloads program images. Optional grant and response stalling exercises the prefetch buffer's outstanding-transaction handling.

## Interface
- `MEM_DEPTH`, default 1024: array size in 32-bit words; must be a power of 2.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be word aligned.
- `MAX_OUTSTANDING`, default 2: number of granted requests not yet answered; range 1..4.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `instr_req_i` input 1: fetch request.
- `instr_addr_i` input 32: byte address; bits [1:0] ignored.
- `instr_gnt_o` output 1: request accepted this cycle.
- `instr_rvalid_o` output 1: response valid, one cycle per granted request.
- `instr_rdata_o` output 32: instruction word.
- `instr_err_o` output 1: bus error; valid with `instr_rvalid_o`.
- `load_we_i` input 1: backdoor write enable.
- `load_addr_i` input $clog2(MEM_DEPTH): backdoor word index.
- `load_wdata_i` input 32: backdoor write data.
- `gnt_stall_i` input 4: grant stall cycles; used only with the macro.
- `rvalid_lat_i` input 4: extra response latency; used only with the macro.
- `outstanding_o` output 3: current outstanding count.

## Operation
- **Accept.** A request is accepted when `instr_req_i & instr_gnt_o`.
  - `instr_gnt_o = instr_req_i & (count < MAX_OUTSTANDING) & stall_done & ~rst`. This is combinational.
- **Address decode.**
  - `off = instr_addr_i - BASE_ADDR`.
  - The access is in range when `instr_addr_i >= BASE_ADDR` and `off[31:2] < MEM_DEPTH`.
  - Word index is `off[$clog2(MEM_DEPTH)+1:2]`.
- **Read.**
  - The array is read at accept time. The entry `{rdata, err}` is pushed into an in-order response FIFO of depth MAX_OUTSTANDING.
  - An out-of-range access gives `err=1` and `rdata=0`.
- **Response.**
  - The FIFO head retires as a registered `instr_rvalid_o` pulse, carrying `instr_rdata_o` and `instr_err_o`.
  - The OBI bus has no backpressure, so the responder can never be blocked when it returns a response.
  - `instr_rdata_o` and `instr_err_o` hold their last values between pulses.
- **Count.**
  - Count increments on accept and decrements on rvalid.
  - On a simultaneous accept and rvalid, count is unchanged.
  - `outstanding_o` reflects the count.
- **Backdoor load.**
  - The write lands at the clock edge.
  - If a fetch is accepted in the same cycle to the same word, the fetch returns the old data.
  - The backdoor write has priority over nothing else; it is always performed.
- **Reset.**
  - The FIFO is flushed and count=0.
  - `instr_rvalid_o=0`, `instr_err_o=0`, `instr_rdata_o=0`, `instr_gnt_o=0`.
  - The stall FSM goes to IDLE.
  - Array contents are retained.
  - Responses pending when reset is asserted are dropped, never emitted.
- **Protocol expectation on the master.** The master holds `instr_addr_i` stable while `instr_req_i` is high and ungranted. The responder does not check this.

## Timing
- Without the macro:
  - Accept in cycle N gives rvalid in cycle N+1.
  - Sustained throughput is 1 request/cycle when MAX_OUTSTANDING ≥ 2.
  - With MAX_OUTSTANDING=1, throughput is one request every 2 cycles.
- With the macro:
  - Accept in cycle N gives rvalid at N+1+L, where L = `rvalid_lat_i` sampled at accept.
  - Responses stay in order. A later entry whose timer has expired waits behind the head.
- **Stall FSM** (macro only):
  - IDLE → STALL when `instr_req_i` is high and `gnt_stall_i` ≠ 0. The counter loads `gnt_stall_i` and gnt is withheld.
  - STALL decrements each cycle. `stall_done` is asserted when the counter equals 0, and gnt follows on that cycle.
  - After an accept, return to IDLE. The next request is stalled again.
  - `gnt_stall_i`=0 means no stall; the FSM stays in IDLE.
  - If `instr_req_i` drops during STALL (illegal OBI), the FSM returns to IDLE.
- Full FIFO: gnt is withheld regardless of stall state.

## Configuration
- `CV32E40P_OBI_RESP_STALL_EN`:
  - **Defined:** the stall FSM and per-entry latency timers are compiled in, and `gnt_stall_i`/`rvalid_lat_i` are honoured.
  - **Undefined:** there is no FSM and no timers. `stall_done=1` and latency is fixed at 1. Both inputs are ignored but the ports remain.

## Test plan
- **Basic fetch:** preload word 0 = 32'h0000_0013 and word 1 = 32'h0040_0093. Then request 0x0, then 0x4, back-to-back with the req held. Expect gnt both cycles and rvalid in the two following cycles with those data, err=0.
- **Out of range:** MEM_DEPTH=1024, request 0x0000_1000. Expect gnt, then rvalid with err=1 and rdata=0. A request at `BASE_ADDR`-4 with `BASE_ADDR`=0x100 also gives err=1.
- **Full FIFO:** MAX_OUTSTANDING=2 with the macro, `rvalid_lat_i`=3, req held. Expect gnt in cycles 0 and 1, gnt low until the first rvalid in cycle 4, and `outstanding_o` reaching 2.
- **Grant stall:** with the macro, `gnt_stall_i`=2 and req asserted in cycle 0. Expect gnt in cycle 2 and rvalid in cycle 3.
- **Load collision:** accept a fetch of word 5 (old value 32'hAAAA_AAAA) while `load_we_i` writes 32'h5555_5555 to word 5. Expect the response 32'hAAAA_AAAA; a next fetch of word 5 returns 32'h5555_5555.
- **Reset mid-flight:** two outstanding requests, then `rst` for 1 cycle. Expect no rvalid afterwards, `outstanding_o`=0, and the preloaded data still readable.

Source files
------------

// File: rtl/cv32e40p_obi_instr_responder.sv
// cv32e40p_obi_instr_responder: OBI instruction-fetch responder backed by a word array.
// Optional grant stalling and per-response latency are enabled with CV32E40P_OBI_RESP_STALL_EN.
module cv32e40p_obi_instr_responder #(
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         load_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_i,
    input  logic [31:0]                  load_wdata_i,
    input  logic [3:0]                   gnt_stall_i,
    input  logic [3:0]                   rvalid_lat_i,
    output logic [2:0]                   outstanding_o
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   in_data;
    logic          in_err;
    logic          not_full;
    logic          stall_done;
    logic          accept;
    logic [2:0]    cnt;
    logic [31:0]   fifo_data [MAX_OUTSTANDING];
    logic          fifo_err [MAX_OUTSTANDING];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    fifo_cnt;
    logic          head_valid;
    logic          head_ready;
    logic          in_ready;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          unused_ok;

    assign off        = instr_addr_i - BASE_ADDR;
    assign in_range   = (instr_addr_i >= BASE_ADDR) && (off[31:2] < 30'(MEM_DEPTH));
    assign idx        = off[AW+1:2];
    assign in_err     = ~in_range;
    assign in_data    = in_range ? mem[idx] : '0;
    assign not_full   = cnt < 3'(MAX_OUTSTANDING);
    assign instr_gnt_o = instr_req_i & not_full & stall_done & ~rst;
    assign accept     = instr_req_i & instr_gnt_o;
    // Stored entries go first; an accepted fetch skips the FIFO only when nothing is queued ahead of it.
    assign head_valid = fifo_cnt != 3'd0;
    assign pop        = head_valid & head_ready;
    assign bypass     = ~head_valid & accept & in_ready;
    assign push       = accept & ~bypass;

    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign outstanding_o  = cnt;

`ifdef CV32E40P_OBI_RESP_STALL_EN
    typedef enum logic {IDLE, STALL} state_e;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] stall_q;
    logic [3:0] stall_d;
    logic [3:0] lat_q [MAX_OUTSTANDING];

    assign stall_done = (state_q == STALL) ? (stall_q == 4'd0) : (gnt_stall_i == 4'd0);
    assign head_ready = lat_q[rd_ptr] == 4'd0;
    assign in_ready   = rvalid_lat_i == 4'd0;
    assign unused_ok  = ^off[1:0];

    // Stall next state: the counter is loaded one short so gnt lands exactly gnt_stall_i cycles after req.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        if (state_q == IDLE) begin
            if (instr_req_i && gnt_stall_i != 4'd0) begin
                state_d = STALL;
                stall_d = gnt_stall_i - 4'd1;
            end
        end else if (!instr_req_i || accept) begin
            state_d = IDLE;
        end else if (stall_q != 4'd0) begin
            stall_d = stall_q - 4'd1;
        end
    end

    // Stall state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stall_q <= 4'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Per-entry latency timers count down while queued; a stored value of 0 means ready to retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) lat_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) if (lat_q[i] != 4'd0) lat_q[i] <= lat_q[i] - 4'd1;
            if (push) lat_q[wr_ptr] <= (rvalid_lat_i == 4'd0) ? 4'd0 : rvalid_lat_i - 4'd1;
        end
    end
`else
    assign stall_done = 1'b1;
    assign head_ready = 1'b1;
    assign in_ready   = 1'b1;
    assign unused_ok  = ^{off[1:0], gnt_stall_i, rvalid_lat_i};
`endif

    // Backdoor write; a fetch reading the same word this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (load_we_i) mem[load_addr_i] <= load_wdata_i;
    end

    // Response FIFO, outstanding count and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= 3'd0;
            cnt      <= 3'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= in_data;
                fifo_err[wr_ptr]  <= in_err;
                wr_ptr            <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
            cnt      <= cnt + 3'(accept) - 3'(rvalid_q);
            rvalid_q <= pop | bypass;
            if (pop) begin
                rdata_q <= fifo_data[rd_ptr];
                err_q   <= fifo_err[rd_ptr];
            end else if (bypass) begin
                rdata_q <= in_data;
                err_q   <= in_err;
            end
        end
    end
endmodule
